// File: rtl/sqrt_pipe_tagged.sv
// sqrt_pipe_tagged: pipelined restoring square root with a payload carried in lockstep.
// One global advance enable; the last stage register drives the outputs.
module sqrt_pipe_tagged #(
    parameter int WIDTH          = 32,
    parameter int Q_BITS         = 16,
    parameter int PAYLOAD_W      = 160,
    parameter int BITS_PER_STAGE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     x_in,
    input  logic [PAYLOAD_W-1:0] payload_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     len_out,
    output logic [PAYLOAD_W-1:0] payload_out,
    output logic                 err_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int RAD_W     = WIDTH + Q_BITS;
    localparam int ROOT_BITS = RAD_W / 2;
    localparam int NSTAGE    = ROOT_BITS / BITS_PER_STAGE;
    localparam int REM_W     = ROOT_BITS + 2;

    if ((RAD_W % 2) != 0) begin : g_bad_even
        $error("WIDTH+Q_BITS must be even");
    end
    if (ROOT_BITS > WIDTH - 1) begin : g_bad_root
        $error("ROOT_BITS must not exceed WIDTH-1");
    end
    if (BITS_PER_STAGE != 1 && BITS_PER_STAGE != 2 && BITS_PER_STAGE != 4) begin : g_bad_bps
        $error("BITS_PER_STAGE must be 1, 2 or 4");
    end
    if ((ROOT_BITS % BITS_PER_STAGE) != 0) begin : g_bad_div
        $error("BITS_PER_STAGE must divide ROOT_BITS");
    end

    typedef struct packed {
        logic                 vld;
        logic                 err;
        logic [REM_W-1:0]     rem;
        logic [ROOT_BITS-1:0] root;
        logic [RAD_W-1:0]     rad;
        logic [PAYLOAD_W-1:0] pl;
    } stage_t;

    stage_t st [NSTAGE];
    stage_t s_in;
    logic   en;

    // Resolve BITS_PER_STAGE root bits, MSB first, consuming two radicand bits each.
    function automatic stage_t step(input stage_t s);
        stage_t           r;
        logic [REM_W+1:0] cur;
        logic [REM_W+1:0] trial;
        r = s;
        for (int i = 0; i < BITS_PER_STAGE; i++) begin
            cur   = {r.rem, r.rad[RAD_W-1 -: 2]};
            trial = {2'b00, r.root, 2'b01};
            if (cur >= trial) begin
                r.rem  = REM_W'(cur - trial);
                r.root = {r.root[ROOT_BITS-2:0], 1'b1};
            end else begin
                r.rem  = REM_W'(cur);
                r.root = {r.root[ROOT_BITS-2:0], 1'b0};
            end
            r.rad = {r.rad[RAD_W-3:0], 2'b00};
        end
        return r;
    endfunction

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Build the stage-0 seed; a negative input becomes a zero radicand with err set.
    always_comb begin
        s_in      = '0;
        s_in.vld  = in_valid;
        s_in.err  = x_in[WIDTH-1];
        s_in.pl   = payload_in;
        s_in.rad  = x_in[WIDTH-1] ? '0 : {x_in, {Q_BITS{1'b0}}};
    end

    // Shift the whole pipe forward when enabled, otherwise hold every stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NSTAGE; i++) begin
                st[i] <= '0;
            end
        end else if (en) begin
            st[0] <= step(s_in);
            for (int i = 1; i < NSTAGE; i++) begin
                st[i] <= step(st[i-1]);
            end
        end
    end

    // Any valid stage means the unit is busy.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NSTAGE; i++) begin
            busy = busy | st[i].vld;
        end
    end

    assign out_valid   = st[NSTAGE-1].vld;
    assign err_out     = st[NSTAGE-1].err;
    assign payload_out = st[NSTAGE-1].pl;
    assign len_out     = {{(WIDTH-ROOT_BITS){1'b0}}, st[NSTAGE-1].root};

endmodule

// File: doc/sqrt_pipe_tagged.md
# sqrt_pipe_tagged

Pipelined fixed-point square-root unit. It computes the ray-direction length from a squared-magnitude input and carries an opaque side-band payload (tag and direction) through the same pipeline, so payloads cannot fall out of step with results. It uses an in-house digit-by-digit core instead of the vendor CORDIC, and has full valid/ready back-pressure on both sides. It sits between the dot-product (squared-length) stage and the normalisation stage of the ray-generation path.

## Interface
- WIDTH, `WIDTH` (32): input and result word width, signed Q format.
- Q_BITS, `Q_BITS` (16): fractional bits of input and result.
- PAYLOAD_W, 160: width of the opaque payload (tag plus direction), passed through unmodified.
- BITS_PER_STAGE, 1: root bits resolved per pipeline stage. Legal values are 1, 2 and 4, and the value must divide ROOT_BITS.
- Derived: ROOT_BITS = (WIDTH+Q_BITS)/2, and NSTAGE = ROOT_BITS/BITS_PER_STAGE. WIDTH+Q_BITS must be even and ROOT_BITS ≤ WIDTH-1; violating either is an elaboration error.

Ports:
- clk, in, 1: the single clock.
- reset, in, 1: synchronous, active-high.
- x_in, in, WIDTH: squared length, signed Q(WIDTH-Q_BITS).Q_BITS.
- payload_in, in, PAYLOAD_W: side-band data captured together with x_in.
- in_valid, in, 1: input beat valid.
- in_ready, out, 1: unit can accept a beat this cycle.
- len_out, out, WIDTH: floor square root in the same Q format, zero-extended.
- payload_out, out, PAYLOAD_W: payload belonging to len_out.
- err_out, out, 1: input was negative, and len_out is forced to 0.
- out_valid, out, 1: output beat valid.
- out_ready, in, 1: downstream accepts the beat.
- busy, out, 1: at least one stage holds a valid beat.

## Operation
- Radicand R = {x_in, Q_BITS'b0}, which is WIDTH+Q_BITS bits treated as unsigned. Result = floor(sqrt(R)), which is ROOT_BITS bits wide and placed in the LSBs of len_out with the upper bits 0. Rounding is truncation only.
- The core is a restoring digit-by-digit square root. Each stage holds a remainder (ROOT_BITS+2 bits), a partial root, the remaining radicand bits, the payload, an err bit and a valid bit. A stage resolves BITS_PER_STAGE root bits, MSB first.
- Negative input (x_in[WIDTH-1]=1):
  - R is replaced by 0 and err is set in the stage-0 register.
  - The beat flows through normally and exits with len_out=0 and err_out=1.
  - The payload is still delivered.
- Accept condition: in_valid && in_ready. A beat is captured into stage 0 at that edge.
- Global advance enable: en = !out_valid || out_ready.
  - When en=1, every stage shifts forward by one.
  - When en=0, all stages hold, including the valid bits.
- in_ready = en. This is a combinational path from out_ready and is intentional.
- Bubbles: a stage whose valid bit is 0 shifts like any other stage. Bubbles are not squeezed out.
- The last stage register drives len_out, payload_out, err_out and out_valid directly.
- busy = OR of all stage valid bits.
- Order is strictly preserved: beats leave in acceptance order.

## Timing
- Latency: NSTAGE cycles with no stall. A beat accepted at edge t has out_valid=1 in the cycle after edge t+NSTAGE-1.
  - Default configuration: NSTAGE=24, latency 24.
  - With BITS_PER_STAGE=4: NSTAGE=6, latency 6.
- Throughput: 1 beat per cycle while out_ready=1.
- Stall: out_valid=1 with out_ready=0 freezes the whole pipe and deasserts in_ready. The output beat stays stable (value and payload) until the handshake completes.
- Simultaneous output handshake and input accept in the same cycle is legal. There is no loss and no duplication.
- Reset:
  - Takes effect at the next clk edge.
  - Clears all stage valid bits. out_valid, busy and err_out go to 0; len_out and payload_out go to 0.
  - in_ready is 1 in the first cycle after reset.
  - In-flight beats are discarded silently. An in_valid asserted in the reset cycle is not accepted.
- Boundaries:
  - x_in=0 gives len_out=0 and err_out=0.
  - The maximum positive x_in gives an all-ones-limited root and must not overflow into bit ROOT_BITS.

## Test plan
- Default parameters, x_in=0x0004_0000 (4.0) with payload 0xA5: after 24 cycles, len_out=0x0002_0000, payload_out=0xA5, err_out=0.
- x_in=0x0002_0000 yields len_out=0x0001_6A09. x_in=0x7FFF_FFFF yields len_out=0x00B5_04F3. x_in=0 yields len_out=0.
- x_in=0xFFFF_0000 (negative) yields len_out=0 and err_out=1, and its payload is delivered.
- Back-to-back stream of 100 random beats with out_ready randomly toggled:
  - Results match the floor-sqrt model in order.
  - in_ready = !out_valid || out_ready in every cycle.
  - No beat is lost or duplicated, and the output stays stable while stalled.
- BITS_PER_STAGE=4 build: latency is exactly 6 cycles and results are identical to the BITS_PER_STAGE=1 model.
- Reset asserted with 10 beats in flight:
  - Next cycle: out_valid=0, busy=0, in_ready=1.
  - None of the discarded beats ever appear at the output.
